// File: rtl/mp3_pkg.sv
// Shared MP3 Layer III framing constants, field structs and bit-packing helpers.
// Used by side_info_framer and crc16_mp3.
package mp3_pkg;

    localparam logic [11:0] MP3_SYNC   = 12'hFFF;
    localparam int          HDR_BYTES  = 4;
    localparam int          SIDE_BYTES = 32;
    localparam int          SIDE_BITS  = SIDE_BYTES * 8;
    localparam int          FRAME_BITS = (HDR_BYTES + SIDE_BYTES) * 8;
    // Protected span: header bytes 2-3 followed by the whole side info
    localparam int          CRC_BITS   = 16 + SIDE_BITS;
    localparam logic [15:0] CRC_POLY   = 16'h8005;
    localparam logic [15:0] CRC_INIT   = 16'hFFFF;

    typedef enum logic [2:0] {
        IDLE,
        CRC_CALC,
        HDR,
        CRC_OUT,
        SIDE,
        DONE
    } state_t;

    typedef struct packed {
        logic [3:0] bitrate_index;
        logic [1:0] sample_rate_index;
        logic       padding;
        logic       prot;
        logic [1:0] mode;
        logic [1:0] mode_ext;
        logic [1:0] emphasis;
    } hdr_t;

    typedef struct packed {
        logic [11:0]     part2_3_length;
        logic [8:0]      big_values;
        logic [7:0]      global_gain;
        logic [3:0]      scalefac_compress;
        logic            window_switching_flag;
        logic [1:0]      block_type;
        logic            mixed_block_flag;
        logic [2:0][4:0] table_select;
        logic [2:0][2:0] subblock_gain;
        logic [3:0]      region0_count;
        logic [3:0]      region1_count;
        logic            preflag;
        logic            scalefac_scale;
        logic            count1table_select;
    } gc_t;

    // gc is indexed [granule][channel]
    typedef struct packed {
        logic [8:0]      main_data_begin;
        logic [2:0]      private_bits;
        logic [1:0][3:0] scfsi;
        gc_t [1:0][1:0]  gc;
    } side_t;

    function automatic logic [58:0] pack_gc(input gc_t g);
        logic [21:0] br;
        if (g.window_switching_flag)
            br = {g.block_type, g.mixed_block_flag, g.table_select[0], g.table_select[1],
                  g.subblock_gain[0], g.subblock_gain[1], g.subblock_gain[2]};
        else
            br = {g.table_select[0], g.table_select[1], g.table_select[2],
                  g.region0_count, g.region1_count[2:0]};
        return {g.part2_3_length, g.big_values, g.global_gain, g.scalefac_compress,
                g.window_switching_flag, br, g.preflag, g.scalefac_scale, g.count1table_select};
    endfunction

    function automatic logic [SIDE_BITS-1:0] pack_side(input side_t s);
        return {s.main_data_begin, s.private_bits, s.scfsi[0], s.scfsi[1],
                pack_gc(s.gc[0][0]), pack_gc(s.gc[0][1]),
                pack_gc(s.gc[1][0]), pack_gc(s.gc[1][1])};
    endfunction

    function automatic logic [31:0] pack_hdr(input hdr_t h, input logic prot_bit);
        return {MP3_SYNC, 1'b1, 2'b01, prot_bit,
                h.bitrate_index, h.sample_rate_index, h.padding, 1'b0,
                h.mode, h.mode_ext, 1'b0, 1'b0, h.emphasis};
    endfunction

endpackage

// File: rtl/side_info_framer_if.sv
// Request fields plus byte-stream handshake between a producer and side_info_framer.
interface side_info_framer_if;
    import mp3_pkg::*;

    logic       start;
    hdr_t       hdr;
    side_t      side;
    logic [7:0] axiod;
    logic       axiov;
    logic       axior;
    logic       busy;
    logic       done;

    modport master (
        input  start, hdr, side, axior,
        output axiod, axiov, busy, done
    );

    modport slave (
        output start, hdr, side, axior,
        input  axiod, axiov, busy, done
    );
endinterface

// File: rtl/crc16_mp3.sv
// Bit-serial CRC-16 (poly 0x8005, MSB first, no reflection, no final xor).
module crc16_mp3
    import mp3_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        init,
    input  logic        en,
    input  logic        din,
    output logic [15:0] crc
);

    logic fb;
    assign fb = crc[15] ^ din;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            crc <= CRC_INIT;
        else if (init)
            crc <= CRC_INIT;
        else if (en)
            crc <= {crc[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
    end

endmodule

// File: rtl/side_info_framer.sv
// Emits a 4-byte MP3 header plus 32 bytes of Layer III side info as a ready/valid byte stream.
// Optional CRC_EN: CRC-16 over header bytes 2-3 and side info, inserted after the header.
module side_info_framer
    import mp3_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    side_info_framer_if.master        bus
);

    state_t                  state;
    logic [FRAME_BITS-1:0]   rest;      // bytes still to send, current byte already in axiod
    logic [FRAME_BITS-1:0]   frame_in;
    logic [8:0]              cnt;
    logic                    xfer;
    logic                    prot_bit;

`ifdef CRC_EN
    logic        crc_on;
    logic        crc_init;
    logic        crc_en;
    logic        crc_din;
    logic [8:0]  crc_idx;
    logic [15:0] crc;

    assign prot_bit = bus.hdr.prot;
    assign crc_init = (state == IDLE) && bus.start;
    assign crc_en   = (state == CRC_CALC);
    // rest holds the frame minus its first byte, so the protected span starts at bit FRAME_BITS-9
    assign crc_idx  = 9'(FRAME_BITS - 9) - cnt;
    assign crc_din  = rest[crc_idx];

    crc16_mp3 u_crc (
        .clk  (clk),
        .rst  (rst),
        .init (crc_init),
        .en   (crc_en),
        .din  (crc_din),
        .crc  (crc)
    );
`else
    // No CRC support in this build: frame always advertises "not protected"
    assign prot_bit = 1'b1 | bus.hdr.prot;
`endif

    assign frame_in = {pack_hdr(bus.hdr, prot_bit), pack_side(bus.side)};
    assign xfer     = bus.axiov && bus.axior;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rest      <= '0;
            cnt       <= '0;
            bus.axiod <= '0;
            bus.axiov <= 1'b0;
            bus.busy  <= 1'b0;
            bus.done  <= 1'b0;
`ifdef CRC_EN
            crc_on    <= 1'b0;
`endif
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        rest      <= {frame_in[FRAME_BITS-9:0], 8'h00};
                        bus.axiod <= frame_in[FRAME_BITS-1 -: 8];
                        bus.busy  <= 1'b1;
                        cnt       <= '0;
`ifdef CRC_EN
                        crc_on    <= ~bus.hdr.prot;
                        if (!bus.hdr.prot) begin
                            state <= CRC_CALC;
                        end else begin
                            state     <= HDR;
                            bus.axiov <= 1'b1;
                        end
`else
                        state     <= HDR;
                        bus.axiov <= 1'b1;
`endif
                    end
                end

`ifdef CRC_EN
                CRC_CALC: begin
                    if (cnt == 9'(CRC_BITS - 1)) begin
                        cnt       <= '0;
                        state     <= HDR;
                        bus.axiov <= 1'b1;
                    end else begin
                        cnt <= cnt + 9'd1;
                    end
                end
`endif

                HDR: begin
                    if (xfer) begin
                        if (cnt == 9'(HDR_BYTES - 1)) begin
                            cnt <= '0;
`ifdef CRC_EN
                            if (crc_on) begin
                                state     <= CRC_OUT;
                                bus.axiod <= crc[15:8];
                            end else begin
                                state     <= SIDE;
                                bus.axiod <= rest[FRAME_BITS-1 -: 8];
                                rest      <= rest << 8;
                            end
`else
                            state     <= SIDE;
                            bus.axiod <= rest[FRAME_BITS-1 -: 8];
                            rest      <= rest << 8;
`endif
                        end else begin
                            cnt       <= cnt + 9'd1;
                            bus.axiod <= rest[FRAME_BITS-1 -: 8];
                            rest      <= rest << 8;
                        end
                    end
                end

`ifdef CRC_EN
                CRC_OUT: begin
                    if (xfer) begin
                        if (cnt == 9'd0) begin
                            cnt       <= 9'd1;
                            bus.axiod <= crc[7:0];
                        end else begin
                            cnt       <= '0;
                            state     <= SIDE;
                            bus.axiod <= rest[FRAME_BITS-1 -: 8];
                            rest      <= rest << 8;
                        end
                    end
                end
`endif

                SIDE: begin
                    if (xfer) begin
                        if (cnt == 9'(SIDE_BYTES - 1)) begin
                            cnt       <= '0;
                            state     <= DONE;
                            bus.axiov <= 1'b0;
                            bus.axiod <= '0;
                            bus.busy  <= 1'b0;
                            bus.done  <= 1'b1;
                        end else begin
                            cnt       <= cnt + 9'd1;
                            bus.axiod <= rest[FRAME_BITS-1 -: 8];
                            rest      <= rest << 8;
                        end
                    end
                end

                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/side_info_framer.md
SIDE_INFO_FRAMER -- requirements
Module: side_info_framer

Interface
REQ-001 SHALL have port clk, input, 1, sole clock (100 MHz system clock).
REQ-002 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port start, input, 1, single-cycle request to emit one frame prefix.
REQ-004 SHALL have header field inputs, each latched on accepted start:
- bitrate_index [3:0]
- sample_rate_index [1:0]
- padding [0:0]
- prot [0:0]
- mode [1:0]
- mode_ext [1:0]
- emphasis [1:0]
REQ-005 SHALL have side-info field inputs, each latched on accepted start:
- main_data_begin [8:0], private_bits [2:0], scfsi [1:0][3:0]
- per granule x channel [1:0][1:0]: part2_3_length [11:0], big_values [8:0], global_gain [7:0], scalefac_compress [3:0], window_switching_flag, block_type [1:0], mixed_block_flag, table_select [2:0][4:0], subblock_gain [2:0][2:0], region0_count [3:0], region1_count [3:0], preflag, scalefac_scale, count1table_select
REQ-006 SHALL have axiod, output, 8, outgoing byte, MSB first in bitstream order.
REQ-007 SHALL have axiov, output, 1, axiod valid.
REQ-008 SHALL have axior, input, 1, downstream ready; a byte transfers when axiov and axior are both high.
REQ-009 SHALL have busy, output, 1, high from accepted start until the last byte transfers.
REQ-010 SHALL have done, output, 1, one-cycle pulse in the cycle after the last byte transfers.

Function
REQ-011 SHALL accept start only in IDLE; start while busy is ignored.
REQ-012 SHALL use FSM states IDLE -> CRC_CALC (CRC_EN only) -> HDR -> CRC_OUT (CRC_EN only) -> SIDE -> DONE -> IDLE.
REQ-013 SHALL emit 4 header bytes in HDR:
- sync 0xFFF, ID=1, layer=01
- protection bit = prot
- bitrate_index, sample_rate_index, padding, private=0
- mode, mode_ext, copyright=0, original=0, emphasis
REQ-014 SHALL emit exactly 32 side-info bytes (256 bits) in SIDE.
REQ-015 SHALL pack side info in this order: main_data_begin, private_bits, scfsi[ch0], scfsi[ch1], then gr0ch0, gr0ch1, gr1ch0, gr1ch1.
REQ-016 SHALL pack each granule/channel block as 59 bits: part2_3_length, big_values, global_gain, scalefac_compress, window_switching_flag, then a 22-bit branch, then preflag, scalefac_scale, count1table_select.
REQ-017 SHALL encode the 22-bit branch by window_switching_flag:
- wsf=1: block_type, mixed_block_flag, table_select[0..1], subblock_gain[0..2]
- wsf=0: table_select[0..2], region0_count, region1_count[2:0] (bit 3 discarded)
REQ-018 SHALL hold axiod and axiov stable while axiov=1 and axior=0.
REQ-019 SHALL present the first byte no later than 2 cycles after start without CRC_EN; axiov SHALL then stay high until the last transfer.
REQ-020 SHALL never drop, repeat or reorder a byte under arbitrary axior patterns.

Reset
REQ-021 SHALL, on rst (including mid-frame), go to IDLE immediately and hold axiov=0, axiod=0, busy=0, done=0; the partial frame is abandoned and not resumed.
REQ-022 SHALL ignore start while rst is high.

Configuration
REQ-023 SHALL, with CRC_EN defined and prot=0, compute CRC-16 (poly 0x8005, init 0xFFFF) over header bytes 2-3 plus all 256 side-info bits in CRC_CALC, then emit it MSB byte first in CRC_OUT, giving 38 bytes total.
REQ-024 SHALL, with CRC_EN defined and prot=1, skip CRC_CALC and CRC_OUT.
REQ-025 SHALL, without CRC_EN, force the header protection bit to 1, ignore prot, and omit CRC logic entirely (36 bytes).

Structure
REQ-026 SHALL take from shared package mp3_pkg: sync constant, side-info byte count (32), header byte count (4), CRC polynomial/init, FSM state enum.
REQ-027 SHALL place the CRC in sub-module crc16_mp3 (bit-serial, 1 bit/cycle), instantiated only under CRC_EN.

Verification
REQ-028 SHALL cover: bitrate_index=9, sample_rate_index=0, prot=1, other header fields 0, axior=1 -> bytes FF FB 90 00, then 32 bytes 0x00, done pulse.
REQ-029 SHALL cover: main_data_begin=0x1FF, all other side-info fields 0 -> side-info bytes 0 and 1 = FF 80, rest 0x00.
REQ-030 SHALL cover: axior low for 5 cycles at side-info byte 10 -> that byte is held stable, and 36 bytes transfer in total.
REQ-031 SHALL cover: rst pulsed at byte 20 -> axiov=0 next edge; a new start then yields a complete frame from FF.
REQ-032 SHALL cover: random fields looped into header_finder + plexer + side_info_2ch -> every decoded field equals the input (region1_count low 3 bits only).
REQ-033 SHALL cover, with CRC_EN and prot=0: 38 bytes, and the CRC bytes match a reference model.
